pixel_scaler: RTL

PIXEL_SCALER -- requirements
Module: pixel_scaler

---
 rtl/zoom_pkg.sv | 59 +++++
 rtl/pipeline_atraso.sv | 34 +++
 rtl/pixel_scaler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zoom_pkg.sv
// Shared definitions for the pixel scaler.
// Holds the mode codes, the FSM state encoding, the tap-flag bundle that travels
// down the ROM-latency pipeline, and small lookups that map a mode to its
// scale shift, direction and averaging-kernel extent.
package zoom_pkg;

    typedef enum logic [2:0] {
        MODO_1X     = 3'b000,
        MODO_UP2    = 3'b001,
        MODO_UP4    = 3'b010,
        MODO_DEC2   = 3'b011,
        MODO_DEC4   = 3'b100,
        MODO_AVG2   = 3'b101,
        MODO_AVG4   = 3'b110,
        MODO_ILEGAL = 3'b111
    } modo_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FINAL = 2'd3
    } estado_e;

    // Per-read side information that must line up with the returning ROM data.
    typedef struct packed {
        logic vld;   // a read was issued in this slot
        logic last;  // last kernel tap of an output pixel (always 1 outside avg)
        logic fin;   // last read of the whole frame
    } flags_t;

    // Scale shift s: 0 for 1x, 1 for x2, 2 for x4.
    function automatic logic [1:0] shift_of(modo_e m);
        case (m)
            MODO_UP2, MODO_DEC2, MODO_AVG2: shift_of = 2'd1;
            MODO_UP4, MODO_DEC4, MODO_AVG4: shift_of = 2'd2;
            default:                        shift_of = 2'd0;
        endcase
    endfunction

    // 1x behaves like an upscale with s=0 (source coord = output coord).
    function automatic logic is_up(modo_e m);
        is_up = (m == MODO_1X) || (m == MODO_UP2) || (m == MODO_UP4);
    endfunction

    function automatic logic is_avg(modo_e m);
        is_avg = (m == MODO_AVG2) || (m == MODO_AVG4);
    endfunction

    // Highest kernel tap index per axis: 2x2 kernel for avg2, 4x4 for avg4.
    function automatic logic [1:0] kmax_of(modo_e m);
        case (m)
            MODO_AVG2: kmax_of = 2'd1;
            MODO_AVG4: kmax_of = 2'd3;
            default:   kmax_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_atraso.sv
// Fixed-depth delay line used to carry read side-information (valid, last-tap,
// final, output address) alongside the ROM access so it arrives together with
// the ROM data.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears every stage
//   d_i  - data entering the line
//   q_o  - data leaving the line, DEPTH cycles later
module pipeline_atraso #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/pixel_scaler.sv
// Image scaler: reads a source image from a ROM and writes a scaled image to a
// RAM. Supports 1x, nearest-neighbour up-scaling (x2, x4), decimation (/2, /4)
// and box-filter averaging (/2, /4).
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   start      - one-cycle request, only looked at in IDLE
//   modo       - scale mode, captured when start is accepted
//   pixel_in   - ROM read data, ROM_LAT cycles after rom_addr
//   rom_addr   - source read address (registered)
//   ram_addr   - destination write address (registered, valid with wren)
//   pixel_out  - destination write data (registered, valid with wren)
//   wren       - write strobe
//   busy       - job in progress (through the done cycle)
//   done       - one-cycle completion pulse
//   err        - last accepted request used the illegal mode
module pixel_scaler
    import zoom_pkg::*;
#(
    parameter int LARGURA_ORIG = 160,
    parameter int ALTURA_ORIG  = 120,
    parameter int PIXEL_W      = 8,
    parameter int ROM_LAT      = 1,
    parameter int RAM_AW       = 19,
    parameter int ROM_AW       = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         modo,
    input  logic [PIXEL_W-1:0] pixel_in,
    output logic [ROM_AW-1:0]  rom_addr,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               wren,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // Counters must hold up to 4x the source dimension.
    localparam int XW  = $clog2(LARGURA_ORIG * 4) + 1;
    localparam int YW  = $clog2(ALTURA_ORIG * 4) + 1;
    localparam int ACW = PIXEL_W + 4;  // 16 taps of PIXEL_W bits
    localparam int PLW = $bits(flags_t) + RAM_AW;

    // Control / issue state
    estado_e             state_q, state_d;
    modo_e               modo_q, modo_d;
    logic                err_q, err_d;
    logic [XW-1:0]       ox_q, ox_d;
    logic [YW-1:0]       oy_q, oy_d;
    logic [1:0]          kx_q, kx_d, ky_q, ky_d;
    logic [RAM_AW-1:0]   oidx_q, oidx_d;      // linear output index = oy*OUT_W+ox
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    flags_t              iss_q, iss_d;
    logic [RAM_AW-1:0]   iss_addr_q, iss_addr_d;

    // Write stage
    logic                wren_q, wren_d;
    logic                fin_q, fin_d;
    logic [PIXEL_W-1:0]  pixel_out_q, pixel_out_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [ACW-1:0]      acc_q, acc_d;

    // Mode-derived geometry
    logic [1:0]          s;
    logic                up, avg;
    logic [1:0]          kmax;
    logic [XW-1:0]       out_w;
    logic [YW-1:0]       out_h;
    logic                tap_last, pix_last;
    logic [ROM_AW-1:0]   sx, sy, rom_nxt;

    always_comb begin
        s     = shift_of(modo_q);
        up    = is_up(modo_q);
        avg   = is_avg(modo_q);
        kmax  = kmax_of(modo_q);
        out_w = up ? (XW'(LARGURA_ORIG) << s) : (XW'(LARGURA_ORIG) >> s);
        out_h = up ? (YW'(ALTURA_ORIG)  << s) : (YW'(ALTURA_ORIG)  >> s);

        tap_last = (kx_q == kmax) && (ky_q == kmax);
        pix_last = (ox_q == out_w - XW'(1)) && (oy_q == out_h - YW'(1));

        // kx/ky stay 0 outside avg modes, so dec and avg share one formula.
        if (up) begin
            sx = ROM_AW'(ox_q) >> s;
            sy = ROM_AW'(oy_q) >> s;
        end else begin
            sx = (ROM_AW'(ox_q) << s) + ROM_AW'(kx_q);
            sy = (ROM_AW'(oy_q) << s) + ROM_AW'(ky_q);
        end
        rom_nxt = sy * ROM_AW'(LARGURA_ORIG) + sx;
    end

    // FSM next state, read issue and raster/kernel iteration
    always_comb begin
        state_d    = state_q;
        modo_d     = modo_q;
        err_d      = err_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        oidx_d     = oidx_q;
        rom_addr_d = rom_addr_q;
        iss_d      = '0;
        iss_addr_d = iss_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    modo_d  = modo_e'(modo);
                    err_d   = (modo_e'(modo) == MODO_ILEGAL);
                    ox_d    = '0;
                    oy_d    = '0;
                    kx_d    = '0;
                    ky_d    = '0;
                    oidx_d  = '0;
                    state_d = (modo_e'(modo) == MODO_ILEGAL) ? ST_FINAL : ST_RUN;
                end
            end
            ST_RUN: begin
                rom_addr_d = rom_nxt;
                iss_d.vld  = 1'b1;
                iss_d.last = tap_last;
                iss_d.fin  = tap_last && pix_last;
                iss_addr_d = oidx_q;
                if (!tap_last) begin
                    if (kx_q == kmax) begin
                        kx_d = '0;
                        ky_d = ky_q + 2'd1;
                    end else begin
                        kx_d = kx_q + 2'd1;
                    end
                end else begin
                    kx_d   = '0;
                    ky_d   = '0;
                    oidx_d = oidx_q + RAM_AW'(1);
                    if (ox_q == out_w - XW'(1)) begin
                        ox_d = '0;
                        oy_d = oy_q + YW'(1);
                    end else begin
                        ox_d = ox_q + XW'(1);
                    end
                    if (pix_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // fin_q is high exactly while the frame's last write is on the bus.
                if (fin_q) state_d = ST_FINAL;
            end
            ST_FINAL: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Side information delayed to meet the ROM data.
    logic [PLW-1:0] p_bus;
    flags_t         p_flags;
    logic [RAM_AW-1:0] p_addr;

    pipeline_atraso #(
        .DEPTH (ROM_LAT),
        .WIDTH (PLW)
    ) u_atraso (
        .clk (clk),
        .rst (rst),
        .d_i ({iss_q, iss_addr_q}),
        .q_o (p_bus)
    );

    assign {p_flags, p_addr} = p_bus;

    // Write stage: pass-through or kernel accumulation
    logic [ACW-1:0] sum;
    logic [2:0]     avg_sh;

    always_comb begin
        wren_d      = 1'b0;
        fin_d       = 1'b0;
        pixel_out_d = pixel_out_q;
        ram_addr_d  = ram_addr_q;
        acc_d       = acc_q;
        sum         = acc_q + ACW'(pixel_in);
        avg_sh      = {s, 1'b0};  // divide by 4^s = number of taps

        if (p_flags.vld) begin
            if (avg) begin
                if (p_flags.last) begin
                    wren_d      = 1'b1;
                    fin_d       = p_flags.fin;
                    pixel_out_d = PIXEL_W'(sum >> avg_sh);
                    ram_addr_d  = p_addr;
                    acc_d       = '0;
                end else begin
                    acc_d = sum;
                end
            end else begin
                wren_d      = 1'b1;
                fin_d       = p_flags.fin;
                pixel_out_d = pixel_in;
                ram_addr_d  = p_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            modo_q      <= MODO_1X;
            err_q       <= 1'b0;
            ox_q        <= '0;
            oy_q        <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            oidx_q      <= '0;
            rom_addr_q  <= '0;
            iss_q       <= '0;
            iss_addr_q  <= '0;
            wren_q      <= 1'b0;
            fin_q       <= 1'b0;
            pixel_out_q <= '0;
            ram_addr_q  <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            modo_q      <= modo_d;
            err_q       <= err_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            oidx_q      <= oidx_d;
            rom_addr_q  <= rom_addr_d;
            iss_q       <= iss_d;
            iss_addr_q  <= iss_addr_d;
            wren_q      <= wren_d;
            fin_q       <= fin_d;
            pixel_out_q <= pixel_out_d;
            ram_addr_q  <= ram_addr_d;
            acc_q       <= acc_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign ram_addr  = ram_addr_q;
    assign pixel_out = pixel_out_q;
    assign wren      = wren_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINAL);
    assign err       = err_q;

endmodule
